unified_mem_arbiter: RTL and testbench

Parametrised shared-memory block for the RV32 core tops. It replaces separate instruction and data memories with one single-port word RAM. NUM_PORTS requesters, such as instruction fetch, the data port and a debug/loader port, reach the RAM through a valid/ready arbiter. The block accepts one access per cycle, returns a registered response one cycle later, and flags misaligned or out-of-range accesses.

---
 rtl/unified_mem_arbiter.sv | 114 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shared single-port word RAM behind a NUM_PORTS valid/ready arbiter.
// One access per cycle, registered response one cycle after the grant.
module unified_mem_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 512,
    parameter int PRIORITY_MODE = 0,
    parameter     INIT_FILE     = ""
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_PORTS*4-1:0]           req_be,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [DATA_WIDTH-1:0]  mem [DEPTH_WORDS];

    logic [PTR_W-1:0]       ptr;
    logic [NUM_PORTS-1:0]   grant_p0;
    logic [PTR_W-1:0]       grant_idx_p0;
    logic                   found;
    int                     cand;

    logic                   sel_we_p0;
    logic [ADDR_WIDTH-1:0]  sel_addr_p0;
    logic [DATA_WIDTH-1:0]  sel_wdata_p0;
    logic [BYTES-1:0]       sel_be_p0;
    logic                   xfer_p0;
    logic                   misaligned_p0;
    logic                   out_of_range_p0;
    logic                   err_p0;
    logic [IDX_W-1:0]       idx_p0;

    // Search order starts at the round-robin pointer, or at port 0 in fixed mode.
    always_comb begin
        grant_p0     = '0;
        grant_idx_p0 = '0;
        found        = 1'b0;
        cand         = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = (PRIORITY_MODE == 0) ? int'(ptr) + i : i;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!found && req_valid[p] && (p == cand)) begin
                    found        = 1'b1;
                    grant_p0[p]  = 1'b1;
                    grant_idx_p0 = PTR_W'(p);
                end
            end
        end
    end

    assign req_ready = grant_p0;
    assign xfer_p0   = |grant_p0;

    always_comb begin
        sel_we_p0    = 1'b0;
        sel_addr_p0  = '0;
        sel_wdata_p0 = '0;
        sel_be_p0    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_p0[p]) begin
                sel_we_p0    = req_we[p];
                sel_addr_p0  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata_p0 = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
                sel_be_p0    = req_be[p*BYTES +: BYTES];
            end
        end
    end

    assign misaligned_p0   = |sel_addr_p0[1:0];
    assign out_of_range_p0 = |sel_addr_p0[ADDR_WIDTH-1:2+IDX_W];
    assign err_p0          = misaligned_p0 | out_of_range_p0;
    assign idx_p0          = sel_addr_p0[2+IDX_W-1:2];

    // ---- p0 -> p1: RAM write at the grant edge; the old word is captured alongside ----
    always_ff @(posedge clk) begin
        if (xfer_p0 && sel_we_p0 && !err_p0) begin
            for (int b = 0; b < BYTES; b++) begin
                if (sel_be_p0[b]) mem[idx_p0][8*b +: 8] <= sel_wdata_p0[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= grant_p0;
            rsp_err   <= xfer_p0 & err_p0;
            rsp_rdata <= (xfer_p0 && !err_p0) ? mem[idx_p0] : '0;
            if (PRIORITY_MODE == 0 && xfer_p0) begin
                ptr <= (grant_idx_p0 == PTR_W'(NUM_PORTS - 1)) ? '0
                                                              : grant_idx_p0 + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: two instances (round-robin and fixed
// priority) share one set of request inputs.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_we = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_be = '0;

    logic [1:0]  req_ready, fx_req_ready;
    logic [1:0]  rsp_valid, fx_rsp_valid;
    logic [31:0] rsp_rdata, fx_rsp_rdata;
    logic        rsp_err, fx_rsp_err;

    logic [31:0] model [512];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.NUM_PORTS(2), .PRIORITY_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    unified_mem_arbiter #(.NUM_PORTS(2), .PRIORITY_MODE(1)) dut_fx (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(fx_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(fx_rsp_valid), .rsp_rdata(fx_rsp_rdata), .rsp_err(fx_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One single-port access: checks the grant before the edge and the response after it.
    task automatic access(input int port, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b, input logic chk,
                          input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        req_valid = '0;
        req_valid[port] = 1'b1;
        req_we = '0;
        req_we[port] = wr;
        req_addr[port*32 +: 32] = a;
        req_wdata[port*32 +: 32] = wd;
        req_be[port*4 +: 4] = b;
        #1 check("req_ready", 32'(req_ready), 32'(1 << port));
        @(posedge clk);
        #1;
        req_valid = '0;
        check("rsp_valid", 32'(rsp_valid), 32'(1 << port));
        if (chk) begin
            check("rsp_rdata", rsp_rdata, exp_rd);
            check("rsp_err", 32'(rsp_err), 32'(exp_err));
        end
    endtask

    initial begin
        // Reset held, then released; idle outputs for 5 cycles.
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle_ready", 32'(req_ready), 32'h0);
            check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
            check("idle_rsp_rdata", rsp_rdata, 32'h0);
        end

        // Both ports valid for 4 cycles: RR alternates, fixed stays on port 0.
        req_we = 2'b00;
        req_addr[31:0] = 32'h0;
        req_addr[63:32] = 32'h4;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            check("fx_ready", 32'(fx_req_ready), 32'h1);
            @(posedge clk);
            #1;
            check("rr_rsp_valid", 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
            check("fx_rsp_valid", 32'(fx_rsp_valid), 32'h1);
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1 check("no_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1 check("rsp_one_cycle_only", 32'(rsp_valid), 32'h0);

        // Fill the whole RAM with a known pattern.
        for (int i = 0; i < 512; i++) begin
            model[i] = 32'hC0DE0000 | 32'(i);
            access(0, 1'b1, 32'(i * 4), model[i], 4'hF, 1'b0, 32'h0, 1'b0);
        end

        // Full write then back-to-back read; write acknowledge returns the old word.
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'hC0DE0004, 1'b0);
        model[4] = 32'hDEADBEEF;
        access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0);

        // Byte-enable merge.
        access(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1, 32'hC0DE0008, 1'b0);
        access(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, 32'h11223344, 1'b0);
        model[8] = 32'h11BB33DD;
        access(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h11BB33DD, 1'b0);

        // be=0000 is a no-op write.
        access(0, 1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 1'b1, 32'hC0DE0009, 1'b0);
        access(0, 1'b0, 32'h24, 32'h0, 4'h0, 1'b1, 32'hC0DE0009, 1'b0);

        // Port 1 writes, port 0 reads it back.
        access(1, 1'b1, 32'h30, 32'h12345678, 4'hF, 1'b1, 32'hC0DE000C, 1'b0);
        model[12] = 32'h12345678;
        access(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1, 32'h12345678, 1'b0);

        // Error accesses: misaligned and out of range, reads and writes.
        access(0, 1'b0, 32'h802, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
        access(0, 1'b0, 32'h12, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
        access(1, 1'b1, 32'h13, 32'hBAADF00D, 4'hF, 1'b1, 32'h0, 1'b1);
        access(0, 1'b1, 32'h800, 32'hBAD0BAD0, 4'hF, 1'b1, 32'h0, 1'b1);

        // Full readback: no error access may have touched the RAM.
        for (int i = 0; i < 512; i++) begin
            access(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b1, model[i], 1'b0);
        end

        // Reset mid-operation: pointer is 1 here (last grant went to port 0).
        @(negedge clk);
        req_we = 2'b00;
        req_addr[31:0] = 32'h10;
        req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = 2'b00;
        #2 rst = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("post_rst_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        req_addr[31:0] = 32'h10;
        req_addr[63:32] = 32'h20;
        req_valid = 2'b11;
        #1 check("post_rst_ptr_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        check("post_rst_rsp_valid2", 32'(rsp_valid), 32'h1);
        check("post_rst_ram_kept", rsp_rdata, 32'hDEADBEEF);
        check("post_rst_err", 32'(rsp_err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
